gpio_apb_arbiter: RTL and testbench
===================================

Name: gpio_apb_arbiter

Overview:
- APB master front-end that shares the single GPIO APB slave (PSEL1 select) between NUM_REQ on-chip requesters.
- Round-robin arbitration selects one request; the block runs the APB SETUP/ACCESS sequence and returns read data or a write completion to the winning requester.
- Sits between the requesters (CPU port, DMA, test port) and the GPIO slave; it is the only driver of the GPIO APB inputs.

Parameters:
- PDATA_SIZE, 32, APB data and address width.
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 16, PREADY wait limit in ACCESS; used only with GPIO_ARB_TIMEOUT_EN.

Ports:
- PCLK  in  1  APB clock; the only clock.
- PRESET  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid; held until accepted.
- req_write  in  NUM_REQ  1=write, 0=read.
- req_addr  in  NUM_REQ*PDATA_SIZE  packed addresses; requester k at [k*PDATA_SIZE +: PDATA_SIZE].
- req_wdata  in  NUM_REQ*PDATA_SIZE  packed write data.
- req_strb  in  NUM_REQ*PDATA_SIZE/8  packed byte strobes.
- req_ready  out  NUM_REQ  one-hot acceptance pulse.
- rsp_valid  out  NUM_REQ  one-hot completion pulse, 1 cycle.
- rsp_rdata  out  PDATA_SIZE  read data, valid with rsp_valid; 0 for writes.
- rsp_err  out  1  timeout flag, valid with rsp_valid.
- PSEL1, PENABLE, PWRITE  out  1  APB controls to the GPIO slave.
- PADDR, PWDATA  out  PDATA_SIZE  APB address/data.
- PSTRB  out  PDATA_SIZE/8  APB strobes.
- PRDATA  in  PDATA_SIZE  slave read data.
- PREADY  in  1  slave ready.

Behaviour:
- Reset (async, PRESET=1):
  - state=IDLE; rr pointer=0, so requester 0 has top priority.
  - All outputs 0: PSEL1, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, req_ready, rsp_valid, rsp_rdata, rsp_err.
- FSM IDLE -> SETUP -> ACCESS -> IDLE.
- IDLE:
  - If any req_valid, pick the first set bit searching from rr pointer upward, wrapping modulo NUM_REQ.
  - req_ready[g]=1 combinationally in this cycle; addr/write/wdata/strb and g are registered at the edge.
  - rr pointer <= (g+1) mod NUM_REQ; next state SETUP.
  - No valid: stay IDLE with APB outputs 0.
- SETUP (1 cycle): PSEL1=1, PENABLE=0, APB fields driven from the latched request; next state ACCESS.
- ACCESS: PSEL1=1, PENABLE=1, fields held stable.
  - PREADY=0: remain in ACCESS.
  - PREADY=1: capture PRDATA if read (else 0); next cycle rsp_valid[g]=1, rsp_err=0; state IDLE.
- Latency:
  - Accept edge -> SETUP 1 cycle -> ACCESS ≥1 cycle -> rsp_valid on the cycle after PREADY.
  - Minimum 3 cycles from req_ready to rsp_valid.
  - Next arbitration happens in the rsp_valid cycle (IDLE), so minimum request-to-request spacing is 3 cycles.
- PSTRB forwarded unchanged; for reads PSTRB is driven 0 per APB.
- Fairness: requester k waits at most NUM_REQ-1 grants.
- Simultaneous events:
  - A requester may assert a new req_valid in its own rsp_valid cycle; it is arbitrated normally but loses to others per pointer.
  - Requests dropped before acceptance are ignored; no error.
- Reset mid-transaction: transaction abandoned, no rsp_valid, APB outputs 0 immediately.
- No address decoding: addresses pass through (GPIO in 0x00000000, out 0xF700EF00, dir 0x08FF10FF).

Optional Feature:
- Macro GPIO_ARB_TIMEOUT_EN.
- Defined:
  - An ACCESS wait counter of width clog2(TIMEOUT_CYCLES+1) is cleared on entering ACCESS.
  - If PREADY is still 0 after TIMEOUT_CYCLES ACCESS cycles, drop PSEL1/PENABLE and return to IDLE.
  - Next cycle: rsp_valid[g]=1, rsp_err=1, rsp_rdata=0.
  - PREADY in the same cycle as the limit wins (normal completion).
- Undefined: no counter; ACCESS waits indefinitely; rsp_err tied 0.

Decomposition:
- Package gpio_apb_pkg:
  - FSM state enum (IDLE, SETUP, ACCESS).
  - GPIO address constants IN_ADR, OUT_ADR, DIR_ADR.
  - Default PDATA_SIZE.
- One sub-module, rr_arbiter: NUM_REQ round-robin picker; inputs req vector and pointer; outputs one-hot grant and index.
- FSM and APB register stage stay in the top.

Test Plan:
- Single read: req0 read 0x00000000, strb 4'hF, slave PRDATA=0x12345678, PREADY=1 → PSEL1 high 2 cycles; rsp_valid=2'b01, rsp_rdata=0x12345678 exactly 3 cycles after req_ready.
- Write with wait states: req1 write 0xF700EF00, wdata 0xA5A5A5A5, strb 4'b0011, PREADY low 3 cycles → PADDR/PWDATA/PSTRB stable throughout ACCESS; rsp_valid=2'b10, rsp_rdata=0.
- Contention: req0 and req1 valid continuously, 6 requests each → grants alternate 0,1,0,1,…; neither requester is granted twice in a row.
- Reset mid-ACCESS: assert PRESET while PENABLE=1 → all outputs 0 in the same cycle; no rsp_valid; the next grant after release goes to requester 0.
- Timeout (macro defined, TIMEOUT_CYCLES=16): PREADY held 0 → rsp_err=1, rsp_rdata=0 after 16 ACCESS cycles. Macro undefined: ACCESS persists for 100 cycles with no response.
- Back-to-back: req0 re-asserts valid in its rsp_valid cycle with req1 idle → regranted immediately; SETUP begins the next cycle.

Source files
------------

// File: rtl/gpio_apb_pkg.sv
// Shared types and constants for the GPIO APB arbiter.
// Holds the APB FSM state encoding and the GPIO register map.
package gpio_apb_pkg;

    localparam int DEFAULT_PDATA_SIZE = 32;

    localparam logic [31:0] IN_ADR  = 32'h0000_0000;
    localparam logic [31:0] OUT_ADR = 32'hF700_EF00;
    localparam logic [31:0] DIR_ADR = 32'h08FF_10FF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: grants the first requester at or above ptr, wrapping modulo NUM_REQ.
// Produces both a one-hot grant and its binary index.
module rr_arbiter
    import gpio_apb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] pos;

    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        gnt = '0;
        idx = '0;
        any = 1'b0;
        sum = '0;
        pos = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            pos = sum[IDX_W-1:0];
            if (!any && req[pos]) begin
                any      = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/gpio_apb_arbiter.sv
// APB master front-end sharing the GPIO slave (PSEL1) between NUM_REQ requesters.
// Define GPIO_ARB_TIMEOUT_EN to bound the ACCESS wait to TIMEOUT_CYCLES and report rsp_err.
module gpio_apb_arbiter
    import gpio_apb_pkg::*;
#(
    parameter int PDATA_SIZE     = DEFAULT_PDATA_SIZE,
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                            PCLK,
    input  logic                            PRESET,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*PDATA_SIZE-1:0]   req_addr,
    input  logic [NUM_REQ*PDATA_SIZE-1:0]   req_wdata,
    input  logic [NUM_REQ*PDATA_SIZE/8-1:0] req_strb,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [PDATA_SIZE-1:0]           rsp_rdata,
    output logic                            rsp_err,
    output logic                            PSEL1,
    output logic                            PENABLE,
    output logic                            PWRITE,
    output logic [PDATA_SIZE-1:0]           PADDR,
    output logic [PDATA_SIZE-1:0]           PWDATA,
    output logic [PDATA_SIZE/8-1:0]         PSTRB,
    input  logic [PDATA_SIZE-1:0]           PRDATA,
    input  logic                            PREADY
);

    localparam int STRB_W = PDATA_SIZE / 8;
    localparam int IDX_W  = $clog2(NUM_REQ);

    apb_state_t state, state_nxt;

    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      sel_idx;
    logic [IDX_W-1:0]      gnt_idx;
    logic [NUM_REQ-1:0]    arb_gnt;
    logic [NUM_REQ-1:0]    gnt_onehot;
    logic                  arb_any;
    logic                  accept;
    logic                  done;
    logic                  timeout_hit;

    logic                  lat_write;
    logic [PDATA_SIZE-1:0] lat_addr;
    logic [PDATA_SIZE-1:0] lat_wdata;
    logic [STRB_W-1:0]     lat_strb;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (sel_idx),
        .any (arb_any)
    );

    assign accept     = (state == IDLE) && arb_any;
    assign done       = (state == ACCESS) && PREADY;
    // Reset must silence req_ready as well, even though it is combinational.
    assign req_ready  = (accept && !PRESET) ? arb_gnt : '0;
    assign gnt_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx;

`ifdef GPIO_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    assign timeout_hit = (state == ACCESS) && !PREADY &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign rsp_err     = err_q;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= timeout_hit;
            if (state == SETUP) begin
                wait_cnt <= '0;
            end else if ((state == ACCESS) && !PREADY && !timeout_hit) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    always_ff @(posedge PCLK or posedge PRESET) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        PSEL1     = 1'b0;
        PENABLE   = 1'b0;
        PWRITE    = 1'b0;
        PADDR     = '0;
        PWDATA    = '0;
        PSTRB     = '0;

        // APB fields come from the latched request for the whole SETUP/ACCESS span.
        if (state != IDLE) begin
            PSEL1  = 1'b1;
            PWRITE = lat_write;
            PADDR  = lat_addr;
            PWDATA = lat_wdata;
            PSTRB  = lat_write ? lat_strb : '0;
        end

        case (state)
            IDLE: begin
                if (arb_any) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                state_nxt = ACCESS;
            end
            ACCESS: begin
                PENABLE = 1'b1;
                if (PREADY || timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rr_ptr    <= '0;
            gnt_idx   <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_strb  <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= '0;
            rsp_rdata <= '0;

            if (accept) begin
                gnt_idx   <= sel_idx;
                rr_ptr    <= (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
                lat_write <= req_write[sel_idx];
                lat_addr  <= req_addr[sel_idx*PDATA_SIZE +: PDATA_SIZE];
                lat_wdata <= req_wdata[sel_idx*PDATA_SIZE +: PDATA_SIZE];
                lat_strb  <= req_strb[sel_idx*STRB_W +: STRB_W];
            end

            // A timeout completes with zero data; PREADY on the limit cycle wins.
            if (done || timeout_hit) begin
                rsp_valid <= gnt_onehot;
                rsp_rdata <= (done && !lat_write) ? PRDATA : '0;
            end
        end
    end

endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// Scoreboard bench for gpio_apb_arbiter: directed requests push expected responses,
// a monitor pops and compares them whenever rsp_valid is seen.
module tb_gpio_apb_arbiter;
    import gpio_apb_pkg::*;

    typedef struct {
        logic [1:0]  vld;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_strb;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL1;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] slave_rdata;
    logic        PREADY;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   wait_cfg = 0;
    int   acc_cnt  = 0;
    int   ptr_model = 0;
    exp_t sb[$];

    gpio_apb_arbiter #(
        .PDATA_SIZE     (32),
        .NUM_REQ        (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL1     (PSEL1),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PRDATA    (slave_rdata),
        .PREADY    (PREADY)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave model: PREADY rises after wait_cfg low ACCESS cycles.
    always @(negedge PCLK) begin
        if (PSEL1 && PENABLE) begin
            PREADY = (acc_cnt == wait_cfg);
            acc_cnt++;
        end else begin
            PREADY  = 1'b0;
            acc_cnt = 0;
        end
    end

    // Monitor: every response must match the oldest outstanding expectation.
    always @(negedge PCLK) begin
        if (!PRESET && (rsp_valid != 2'b00)) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", {62'd0, rsp_valid}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_valid", {62'd0, rsp_valid}, {62'd0, e.vld});
                check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
                check("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
                if (e.cyc >= 0) check("rsp_latency", cyc, e.cyc);
            end
        end
    end

    task automatic expect_rsp(input int k, input logic [31:0] d, input logic e, input int c);
        exp_t x;
        x.vld   = (k == 1) ? 2'b10 : 2'b01;
        x.rdata = d;
        x.err   = e;
        x.cyc   = c;
        sb.push_back(x);
    endtask

    task automatic set_req(input int k, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        req_write[k]          = wr;
        req_addr[k*32 +: 32]  = a;
        req_wdata[k*32 +: 32] = d;
        req_strb[k*4 +: 4]    = s;
        req_valid[k]          = 1'b1;
    endtask

    // Call at a negedge; returns a little after the negedge of the grant cycle.
    task automatic wait_grant(output int g, output int gc);
        bit found;
        found = 1'b0;
        g  = -1;
        gc = -1;
        for (int n = 0; n < 40 && !found; n++) begin
            #1;
            if (req_ready != 2'b00) begin
                found = 1'b1;
                gc    = cyc;
                g     = req_ready[1] ? 1 : 0;
                check("grant_onehot", $countones(req_ready), 1);
            end else begin
                @(negedge PCLK);
            end
        end
        if (!found) check("grant_timeout", 0, 1);
    endtask

    task automatic drop(input logic [1:0] m);
        @(posedge PCLK);
        #1;
        req_valid = req_valid & ~m;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int g, gc, prev, acc, cnt0, cnt1;
        bit seen;

        PRESET      = 1'b1;
        req_valid   = 2'b11;
        req_write   = '0;
        req_addr    = '0;
        req_wdata   = '0;
        req_strb    = '0;
        slave_rdata = '0;
        PREADY      = 1'b0;

        // Reset state: everything quiet even with requests pending.
        @(negedge PCLK);
        #1;
        check("rst_apb_ctl", {61'd0, PSEL1, PENABLE, PWRITE}, 64'd0);
        check("rst_apb_bus", {PADDR, PWDATA}, 64'd0);
        check("rst_req_ready", {62'd0, req_ready}, 64'd0);
        check("rst_rsp", {29'd0, rsp_valid, rsp_err, rsp_rdata}, 64'd0);
        req_valid = 2'b00;
        PRESET    = 1'b0;
        @(negedge PCLK);

        // Single read, zero wait states.
        wait_cfg    = 0;
        slave_rdata = 32'h1234_5678;
        set_req(0, 1'b0, IN_ADR, 32'h0, 4'hF);
        wait_grant(g, gc);
        check("t1_grant", g, ptr_model);
        ptr_model = 1;
        expect_rsp(0, 32'h1234_5678, 1'b0, gc + 3);
        drop(2'b01);
        @(negedge PCLK);
        check("t1_setup", {61'd0, PSEL1, PENABLE, PWRITE}, 64'b100);
        check("t1_setup_addr", {32'd0, PADDR}, {32'd0, IN_ADR});
        check("t1_read_strb", {60'd0, PSTRB}, 64'd0);
        @(negedge PCLK);
        check("t1_access", {62'd0, PSEL1, PENABLE}, 64'b11);
        @(negedge PCLK);
        check("t1_release", {63'd0, PSEL1}, 64'd0);

        // Write with three wait states: fields stable through ACCESS.
        wait_cfg = 3;
        set_req(1, 1'b1, OUT_ADR, 32'hA5A5_A5A5, 4'b0011);
        wait_grant(g, gc);
        check("t2_grant", g, ptr_model);
        ptr_model = 0;
        expect_rsp(1, 32'h0, 1'b0, gc + 6);
        drop(2'b10);
        acc = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge PCLK);
            if (!PSEL1) break;
            check("t2_addr", {32'd0, PADDR}, {32'd0, OUT_ADR});
            check("t2_wdata", {32'd0, PWDATA}, 64'hA5A5_A5A5);
            check("t2_write_strb", {59'd0, PWRITE, PSTRB}, 64'b10011);
            if (PENABLE) acc++;
        end
        check("t2_access_cycles", acc, 4);

        // Contention: both requesters valid for twelve grants.
        wait_cfg    = 0;
        slave_rdata = 32'hCAFE_F00D;
        set_req(0, 1'b0, IN_ADR, 32'h0, 4'hF);
        set_req(1, 1'b1, DIR_ADR, 32'h0F0F_0F0F, 4'hF);
        prev = -1;
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < 12; i++) begin
            wait_grant(g, gc);
            if (g < 0) break;
            check("t3_grant", g, ptr_model);
            if (prev >= 0) check("t3_alternate", {63'd0, g != prev}, 64'd1);
            expect_rsp(g, (g == 0) ? 32'hCAFE_F00D : 32'h0, 1'b0, gc + 3);
            ptr_model = (g + 1) % 2;
            prev = g;
            if (g == 0) cnt0++;
            else cnt1++;
            if (i == 11) drop(2'b11);
            @(negedge PCLK);
        end
        check("t3_count0", cnt0, 6);
        check("t3_count1", cnt1, 6);
        repeat (3) @(negedge PCLK);

        // Reset in the middle of ACCESS: everything drops at once, pointer back to 0.
        wait_cfg = 1000;
        set_req(0, 1'b0, OUT_ADR, 32'h1111_1111, 4'hF);
        wait_grant(g, gc);
        check("t4_grant", g, ptr_model);
        ptr_model = 1;
        drop(2'b01);
        for (int n = 0; n < 10; n++) begin
            @(negedge PCLK);
            if (PENABLE) break;
        end
        check("t4_access_reached", {63'd0, PENABLE}, 64'd1);
        repeat (2) @(negedge PCLK);
        set_req(0, 1'b0, OUT_ADR, 32'h1111_1111, 4'hF);
        set_req(1, 1'b1, DIR_ADR, 32'h2222_2222, 4'hF);
        PRESET = 1'b1;
        #1;
        check("t4_rst_apb_ctl", {61'd0, PSEL1, PENABLE, PWRITE}, 64'd0);
        check("t4_rst_paddr", {32'd0, PADDR}, 64'd0);
        check("t4_rst_pwdata", {32'd0, PWDATA}, 64'd0);
        check("t4_rst_req_ready", {62'd0, req_ready}, 64'd0);
        check("t4_rst_rsp", {29'd0, rsp_valid, rsp_err, rsp_rdata}, 64'd0);
        wait_cfg = 0;
        repeat (2) @(negedge PCLK);
        PRESET    = 1'b0;
        ptr_model = 0;
        wait_grant(g, gc);
        check("t4_post_rst_grant", g, ptr_model);
        if (g >= 0) expect_rsp(g, (g == 0) ? 32'hCAFE_F00D : 32'h0, 1'b0, gc + 3);
        ptr_model = 1;
        drop(2'b11);
        repeat (4) @(negedge PCLK);

        // Slave that never answers.
        wait_cfg = 1000;
        set_req(1, 1'b0, DIR_ADR, 32'h0, 4'hF);
        wait_grant(g, gc);
        check("t5_grant", g, ptr_model);
        ptr_model = 0;
`ifdef GPIO_ARB_TIMEOUT_EN
        expect_rsp(1, 32'h0, 1'b1, gc + 18);
        drop(2'b10);
        repeat (20) @(negedge PCLK);
        check("t5_idle_after_timeout", {63'd0, PSEL1}, 64'd0);
`else
        drop(2'b10);
        @(negedge PCLK);
        acc = 0;
        repeat (100) begin
            @(negedge PCLK);
            if (PSEL1 && PENABLE) acc++;
        end
        check("t5_access_persist", acc, 100);
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);
`endif
        wait_cfg = 0;

        // Back-to-back: req0 re-requests in its own rsp_valid cycle.
        slave_rdata = 32'h0BAD_BEEF;
        set_req(0, 1'b0, OUT_ADR, 32'h0, 4'hF);
        wait_grant(g, gc);
        check("t6_grant", g, ptr_model);
        expect_rsp(0, 32'h0BAD_BEEF, 1'b0, gc + 3);
        drop(2'b01);
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge PCLK);
            if (rsp_valid[0]) begin
                seen = 1'b1;
                break;
            end
        end
        check("t6_rsp_seen", {63'd0, seen}, 64'd1);
        slave_rdata = 32'h55AA_33CC;
        set_req(0, 1'b0, DIR_ADR, 32'h0, 4'hF);
        #1;
        check("t6_regrant", {62'd0, req_ready}, 64'b01);
        expect_rsp(0, 32'h55AA_33CC, 1'b0, cyc + 3);
        drop(2'b01);
        @(negedge PCLK);
        check("t6_setup", {62'd0, PSEL1, PENABLE}, 64'b10);
        check("t6_addr", {32'd0, PADDR}, {32'd0, DIR_ADR});

        repeat (6) @(negedge PCLK);
        check("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
